ddr_maint_sched: RTL

- APB-clock-domain scheduler that generates DDR maintenance requests for the memory controller user interface: periodic refresh, periodic ZQ calibration and software-requested self-refresh.
- Sits between the DDR APB register block and the controller. It drives the controller's refresh, ZQ and self-refresh request inputs, consumes the matching ack/active signals, and returns status for register readback.
- Requests use a level handshake: each request is held until its acknowledge arrives or a timeout expires.

---
 rtl/ddr_maint_sched_if.sv | 20 ++
 rtl/ddr_maint_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ddr_maint_sched_if.sv
// Maintenance handshake between the scheduler (master) and the DDR controller
// user interface (slave): level requests with pulse acks and a self-refresh status.
interface ddr_maint_sched_if;
  logic o_ref_req;
  logic i_ref_ack;
  logic o_zq_req;
  logic i_zq_ack;
  logic o_sr_req;
  logic i_sr_active;

  modport master (
    output o_ref_req, o_zq_req, o_sr_req,
    input  i_ref_ack, i_zq_ack, i_sr_active
  );

  modport slave (
    input  o_ref_req, o_zq_req, o_sr_req,
    output i_ref_ack, i_zq_ack, i_sr_active
  );
endinterface

// File: rtl/ddr_maint_sched.sv
// DDR maintenance scheduler: periodic refresh and ZQ requests with postponed
// refresh credits, plus software-driven self-refresh entry/exit.
module ddr_maint_sched #(
  parameter int unsigned ack_timeout = 255,
  parameter int unsigned max_pending = 8
) (
  input  logic                     i_apb_clk,
  input  logic                     i_apb_nrst,
  ddr_maint_sched_if.master        ctrl,
  input  logic                     i_enable,
  input  logic                     i_init_calib_done,
  input  logic [15:0]              i_ref_period,
  input  logic [23:0]              i_zq_period,
  input  logic                     i_sr_enter,
  output logic                     o_busy,
  output logic [3:0]               o_ref_pending,
  output logic                     o_ack_timeout,
  output logic                     o_ref_overflow,
  output logic [31:0]              o_ref_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_REF, S_ZQ, S_SR_ENTER, S_SR_ACTIVE, S_SR_EXIT
  } state_t;

  localparam int unsigned        WAIT_W    = $clog2(ack_timeout + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(ack_timeout - 1);
  localparam logic [3:0]         PEND_MAX  = 4'(max_pending);

  state_t              state, state_d;
  logic [15:0]         ref_cnt;
  logic [23:0]         zq_cnt;
  logic [3:0]          pending;
  logic                zq_pending;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                ref_req_q, zq_req_q, sr_req_q;
  logic                ref_req_d, zq_req_d;
  logic                in_sr, run, idle_clear, timer_reload;
  logic                ref_tick, zq_tick, ref_done, zq_done, req_high, req_timeout, sr_exit_done;

  assign in_sr        = state inside {S_SR_ENTER, S_SR_ACTIVE, S_SR_EXIT};
  assign run          = i_enable & i_init_calib_done & ~in_sr;
  assign idle_clear   = ~run & (state == S_IDLE);
  assign sr_exit_done = (state == S_SR_EXIT) & ~ctrl.i_sr_active;
  assign timer_reload = idle_clear | sr_exit_done;

  // Timers count up from 0 and tick on reaching period-1: same cadence as a
  // down-counter loaded with period-1, but with a constant reset value.
  assign ref_tick = run & (i_ref_period != 16'd0) & (ref_cnt >= i_ref_period - 16'd1);
  assign zq_tick  = run & (i_zq_period  != 24'd0) & (zq_cnt  >= i_zq_period  - 24'd1);

  // An ack only counts while its request is actually on the wire.
  assign ref_done    = (state == S_REF) & ref_req_q & ctrl.i_ref_ack;
  assign zq_done     = (state == S_ZQ)  & zq_req_q  & ctrl.i_zq_ack;
  assign req_high    = ref_req_q | zq_req_q;
  assign req_timeout = req_high & (wait_cnt == WAIT_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state;
    ref_req_d = 1'b0;
    zq_req_d  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run && pending != 4'd0)                          state_d = S_REF;
        else if (run && zq_pending)                          state_d = S_ZQ;
        else if (i_sr_enter && i_enable && i_init_calib_done) state_d = S_SR_ENTER;
      end
      S_REF: begin
        if (ref_done || req_timeout) state_d = S_IDLE;
        else                         ref_req_d = 1'b1;
      end
      S_ZQ: begin
        if (zq_done || req_timeout) state_d = S_IDLE;
        else                        zq_req_d = 1'b1;
      end
      S_SR_ENTER: begin
        if (!i_sr_enter)            state_d = S_SR_EXIT;
        else if (ctrl.i_sr_active)  state_d = S_SR_ACTIVE;
      end
      S_SR_ACTIVE: if (!i_sr_enter)        state_d = S_SR_EXIT;
      S_SR_EXIT:   if (!ctrl.i_sr_active)  state_d = S_IDLE;
      default:                             state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_apb_clk or negedge i_apb_nrst) begin
    if (!i_apb_nrst) begin
      state     <= S_IDLE;
      ref_req_q <= 1'b0;
      zq_req_q  <= 1'b0;
      sr_req_q  <= 1'b0;
      o_busy    <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_d;
      ref_req_q <= ref_req_d;
      zq_req_q  <= zq_req_d;
      sr_req_q  <= state_d inside {S_SR_ENTER, S_SR_ACTIVE};
      o_busy    <= state_d != S_IDLE;
      // Counts cycles the current request has been high; 0 on its first high cycle.
      wait_cnt  <= (req_high && (ref_req_d || zq_req_d)) ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_nrst) begin
    if (!i_apb_nrst) begin
      ref_cnt <= '0;
      zq_cnt  <= '0;
    end else if (timer_reload) begin
      ref_cnt <= '0;
      zq_cnt  <= '0;
    end else if (run) begin
      if (i_ref_period != 16'd0) ref_cnt <= ref_tick ? 16'd0 : ref_cnt + 16'd1;
      if (i_zq_period  != 24'd0) zq_cnt  <= zq_tick  ? 24'd0 : zq_cnt  + 24'd1;
    end
  end

  always_ff @(posedge i_apb_clk or negedge i_apb_nrst) begin
    if (!i_apb_nrst) begin
      pending        <= '0;
      zq_pending     <= 1'b0;
      o_ack_timeout  <= 1'b0;
      o_ref_overflow <= 1'b0;
      o_ref_count    <= '0;
    end else begin
      if (idle_clear)                      pending <= '0;
      else if (ref_tick && !ref_done) begin
        if (pending != PEND_MAX)           pending <= pending + 4'd1;
        else                               o_ref_overflow <= 1'b1;
      end else if (ref_done && !ref_tick)  pending <= pending - 4'd1;

      // A fresh tick coinciding with an ack starts a new interval, so set wins.
      if (idle_clear)    zq_pending <= 1'b0;
      else if (zq_tick)  zq_pending <= 1'b1;
      else if (zq_done)  zq_pending <= 1'b0;

      if (req_timeout && !ref_done && !zq_done) o_ack_timeout <= 1'b1;
      if (ref_done) o_ref_count <= o_ref_count + 32'd1;
    end
  end

  assign ctrl.o_ref_req = ref_req_q;
  assign ctrl.o_zq_req  = zq_req_q;
  assign ctrl.o_sr_req  = sr_req_q;
  assign o_ref_pending  = pending;

endmodule
